pad_attr_ctrl: RTL and testbench

Sequencer that safely reconfigures the attributes (drive strength, pull, slew, etc.) of a bank of bidirectional pad cells at runtime. On each request it gates the target pad's output enable, waits a settle interval, applies the new attribute word, waits again, then restores output enable with a new allow setting. It sits between the pad-control register interface and the `pad_attributes_i` / `pad_oe_i` inputs of the pad ring, so attribute changes never glitch a driven pad.

---
 rtl/pad_attr_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pad_attr_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_attr_ctrl.sv
// pad_attr_ctrl: freezes one pad's OE, settles, rewrites its attribute word, settles, then releases OE.
// Latency 2*SETTLE_CYCLES+3 cycles from accept to done_o; req_ready_o is low while a sequence runs, so requests are held off.
module pad_attr_ctrl #(
  parameter int unsigned NUM_PADS = 8,
  parameter int unsigned PADATTR = 16,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [PADATTR-1:0] ATTR_RESET = '0,
  parameter logic [NUM_PADS-1:0] OE_RESET = '1,
  localparam int unsigned IDXW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [IDXW-1:0]               req_pad_idx_i,
  input  logic [PADATTR-1:0]            req_attr_i,
  input  logic                          req_oe_i,
  input  logic [NUM_PADS-1:0]           core_oe_i,
  output logic [NUM_PADS-1:0]           pad_oe_o,
  output logic [NUM_PADS*PADATTR-1:0]   pad_attributes_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o
);

  localparam int unsigned CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES);
  localparam bit NO_SETTLE = (SETTLE_CYCLES == 0);
  localparam logic [IDXW:0] NUM_PADS_W = NUM_PADS[IDXW:0];

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    APPLY,
    POST,
    RELEASE
  } state_t;

  state_t state_q, state_d;

  logic [PADATTR-1:0]  attr_q [NUM_PADS];
  logic [NUM_PADS-1:0] oe_allow_q;
  logic [NUM_PADS-1:0] freeze_q;
  logic [IDXW-1:0]     idx_q;
  logic [PADATTR-1:0]  attr_req_q;
  logic                oe_req_q;
  logic [CW-1:0]       cnt_q;
  logic                done_q;
  logic                err_q;

  logic idx_ok;
  logic latch_req;
  logic bad_req;
  logic cnt_load;
  logic cnt_dec;
  logic do_apply;
  logic do_release;

  assign idx_ok = ({1'b0, req_pad_idx_i} < NUM_PADS_W);

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    latch_req   = 1'b0;
    bad_req     = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    do_apply    = 1'b0;
    do_release  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          if (idx_ok) begin
            latch_req = 1'b1;
            cnt_load  = 1'b1;
            state_d   = NO_SETTLE ? APPLY : PRE;
          end else begin
            bad_req = 1'b1;
          end
        end
      end
      PRE: begin
        // Counter starts at SETTLE_CYCLES, so leaving at 1 gives exactly that many cycles here.
        if (cnt_q <= CW'(1)) begin
          state_d = APPLY;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      APPLY: begin
        do_apply = 1'b1;
        cnt_load = 1'b1;
        state_d  = NO_SETTLE ? RELEASE : POST;
      end
      POST: begin
        if (cnt_q <= CW'(1)) begin
          state_d = RELEASE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RELEASE: begin
        do_release = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NUM_PADS); i++) begin
        attr_q[i] <= ATTR_RESET;
      end
      oe_allow_q <= OE_RESET;
      freeze_q   <= '0;
      idx_q      <= '0;
      attr_req_q <= '0;
      oe_req_q   <= 1'b0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= do_release;
      err_q  <= bad_req;
      if (latch_req) begin
        idx_q                   <= req_pad_idx_i;
        attr_req_q              <= req_attr_i;
        oe_req_q                <= req_oe_i;
        freeze_q[req_pad_idx_i] <= 1'b1;
      end
      if (cnt_load) begin
        cnt_q <= CNT_LOAD;
      end else if (cnt_dec) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (do_apply) begin
        attr_q[idx_q] <= attr_req_q;
      end
      if (do_release) begin
        oe_allow_q[idx_q] <= oe_req_q;
        freeze_q[idx_q]   <= 1'b0;
      end
    end
  end

  // Freeze overrides the functional enable so the pad never drives while its attributes move.
  assign pad_oe_o = core_oe_i & oe_allow_q & ~freeze_q;

  for (genvar g = 0; g < int'(NUM_PADS); g++) begin : g_attr
    assign pad_attributes_o[g*PADATTR +: PADATTR] = attr_q[g];
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign err_o  = err_q;

  a_done_idle: assert property (@(posedge clk_i) disable iff (!rst_ni) done_o |-> !busy_o);
  a_err_idle:  assert property (@(posedge clk_i) disable iff (!rst_ni) err_o |-> !busy_o);
  a_one_frz:   assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(freeze_q));

endmodule

// File: tb/tb_pad_attr_ctrl.sv
// Bench for pad_attr_ctrl: a cycle model plus an event scoreboard over two builds (S=4/8 pads, S=0/6 pads).
module tb_pad_attr_ctrl;

  localparam logic [15:0] A0 = 16'h0000;
  localparam logic [7:0]  OE0 = 8'hFF;
  localparam logic [15:0] A1 = 16'h5A0F;
  localparam logic [7:0]  OE1 = 8'h2D;

  typedef struct {
    int          dut;
    bit          is_err;
    int          due;
    int          idx;
    logic [15:0] attr;
    logic        oe;
  } ev_t;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;

  logic        rst_n [2];
  logic        v [2];
  logic [2:0]  idx [2];
  logic [15:0] at [2];
  logic        oe [2];
  logic [7:0]  core [2];

  logic        rdy0, busy0, done0, err0;
  logic [7:0]  pe0;
  logic [127:0] pa0;
  logic        rdy1, busy1, done1, err1;
  logic [5:0]  pe1;
  logic [95:0] pa1;

  logic [15:0] m_attr [2][8];
  logic [7:0]  m_allow [2];
  bit          act [2];
  int          acc_c [2];
  int          act_idx [2];
  logic [15:0] act_attr [2];
  bit          rst_edge [2] = '{1'b1, 1'b1};
  ev_t         sb [$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_edge[0] <= !rst_n[0];
    rst_edge[1] <= !rst_n[1];
  end

  pad_attr_ctrl u_dut (
    .clk_i(clk), .rst_ni(rst_n[0]), .req_valid_i(v[0]), .req_ready_o(rdy0),
    .req_pad_idx_i(idx[0]), .req_attr_i(at[0]), .req_oe_i(oe[0]), .core_oe_i(core[0]),
    .pad_oe_o(pe0), .pad_attributes_o(pa0), .busy_o(busy0), .done_o(done0), .err_o(err0)
  );

  pad_attr_ctrl #(
    .NUM_PADS(6), .PADATTR(16), .SETTLE_CYCLES(0), .ATTR_RESET(A1), .OE_RESET(OE1[5:0])
  ) u_dut_s0 (
    .clk_i(clk), .rst_ni(rst_n[1]), .req_valid_i(v[1]), .req_ready_o(rdy1),
    .req_pad_idx_i(idx[1]), .req_attr_i(at[1]), .req_oe_i(oe[1]), .core_oe_i(core[1][5:0]),
    .pad_oe_o(pe1), .pad_attributes_o(pa1), .busy_o(busy1), .done_o(done1), .err_o(err1)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int first_ev(input int d);
    for (int i = 0; i < sb.size(); i++) if (sb[i].dut == d) return i;
    return -1;
  endfunction

  task automatic mon(input int d, input logic rdy, input logic busy, input logic done,
                     input logic err, input logic [7:0] pe, input logic [127:0] pa);
    int c, k, np, s, fi;
    ev_t e;
    logic [7:0] oe_e;
    logic [127:0] pa_e;
    bit busy_e;
    c  = cyc;
    np = (d == 0) ? 8 : 6;
    s  = (d == 0) ? 4 : 0;
    if (rst_edge[d]) begin
      for (int i = 0; i < 8; i++) m_attr[d][i] = (d == 0) ? A0 : A1;
      m_allow[d] = (d == 0) ? OE0 : OE1;
      act[d] = 1'b0;
      for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].dut == d) sb.delete(i);
    end else begin
      if (act[d] && (c - acc_c[d] > 2 * s + 2)) act[d] = 1'b0;
      fi = first_ev(d);
      while (fi >= 0 && sb[fi].due < c) begin
        check($sformatf("d%0d_evt_missing", d), 128'(c), 128'(sb[fi].due));
        sb.delete(fi);
        fi = first_ev(d);
      end
      if (done || err) begin
        if (fi < 0) begin
          check($sformatf("d%0d_unexpected_evt", d), 128'({done, err}), 128'(0));
        end else begin
          e = sb[fi];
          sb.delete(fi);
          check($sformatf("d%0d_evt_kind", d), 128'({done, err}), e.is_err ? 128'(1) : 128'(2));
          check($sformatf("d%0d_evt_cycle", d), 128'(c), 128'(e.due));
          if (!e.is_err) begin
            m_attr[d][e.idx]  = e.attr;
            m_allow[d][e.idx] = e.oe;
          end
        end
      end
    end
    k      = c - acc_c[d];
    busy_e = act[d];
    oe_e   = core[d] & m_allow[d] & 8'((1 << np) - 1);
    if (busy_e) oe_e[act_idx[d]] = 1'b0;
    pa_e = '0;
    for (int i = 0; i < np; i++)
      pa_e[i*16 +: 16] = (busy_e && i == act_idx[d] && k >= s + 2) ? act_attr[d] : m_attr[d][i];
    check($sformatf("d%0d_ready", d), 128'(rdy), 128'(!busy_e));
    check($sformatf("d%0d_busy", d), 128'(busy), 128'(busy_e));
    check($sformatf("d%0d_pad_oe", d), 128'(pe), 128'(oe_e));
    check($sformatf("d%0d_pad_attr", d), pa, pa_e);
    if (!busy_e && v[d] && rst_n[d]) begin
      if (int'(idx[d]) < np) begin
        sb.push_back('{d, 1'b0, c + 2 * s + 3, int'(idx[d]), at[d], oe[d]});
        act[d]      = 1'b1;
        acc_c[d]    = c;
        act_idx[d]  = int'(idx[d]);
        act_attr[d] = at[d];
      end else begin
        sb.push_back('{d, 1'b1, c + 1, int'(idx[d]), at[d], oe[d]});
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, rdy0, busy0, done0, err0, pe0, pa0);
    mon(1, rdy1, busy1, done1, err1, {2'b00, pe1}, {32'h0, pa1});
  end

  task automatic send(input int d, input logic [2:0] i, input logic [15:0] a, input logic o,
                      input bit keep, output int acc);
    logic r;
    acc   = -1;
    r     = 1'b0;
    idx[d] = i;
    at[d]  = a;
    oe[d]  = o;
    v[d]   = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      r = (d == 0) ? rdy0 : rdy1;
      if (r) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) check($sformatf("d%0d_accept_timeout", d), 128'(r), 128'(1));
    @(posedge clk);
    #1;
    if (!keep) v[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    logic b;
    b = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      b = (d == 0) ? busy0 : busy1;
      if (!b) break;
    end
    if (b) check($sformatf("d%0d_idle_timeout", d), 128'(b), 128'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int c1, c2;
    bit kp;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; v[d] = 1'b0; idx[d] = '0; at[d] = '0; oe[d] = 1'b0;
    end
    core[0] = 8'hFF;
    core[1] = 8'h3F;
    repeat (2) @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // nominal and OE-disable sequences on the S=4 build
    send(0, 3'd3, 16'hA5A5, 1'b1, 1'b0, c1); wait_idle(0);
    core[0] = 8'hB7;
    send(0, 3'd0, 16'h1234, 1'b0, 1'b0, c1); wait_idle(0);
    repeat (3) @(posedge clk);
    #1;
    send(0, 3'd0, 16'h00FF, 1'b1, 1'b0, c1); wait_idle(0);

    // back-to-back: valid held across the first sequence
    send(0, 3'd5, 16'hBEEF, 1'b1, 1'b1, c1);
    send(0, 3'd7, 16'hC0DE, 1'b0, 1'b0, c2);
    check("d0_b2b_gap", 128'(c2 - c1), 128'(11));
    wait_idle(0);

    // reset landing at edge t0+5 aborts the sequence
    send(0, 3'd6, 16'h7777, 1'b0, 1'b0, c1);
    repeat (4) @(posedge clk);
    #1;
    rst_n[0] = 1'b0;
    @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send(0, 3'd2, 16'h4242, 1'b1, 1'b0, c1); wait_idle(0);

    // S=0 build: out-of-range indices, back-to-back error then update
    send(1, 3'd7, 16'hDEAD, 1'b0, 1'b0, c1);
    send(1, 3'd6, 16'hDEAD, 1'b0, 1'b0, c1);
    send(1, 3'd1, 16'hABCD, 1'b0, 1'b0, c1); wait_idle(1);
    send(1, 3'd7, 16'hFACE, 1'b1, 1'b1, c1);
    send(1, 3'd4, 16'h0F0F, 1'b0, 1'b0, c2);
    check("d1_err_b2b_gap", 128'(c2 - c1), 128'(1));
    wait_idle(1);

    for (int n = 0; n < 12; n++) begin
      core[0] = 8'($urandom);
      kp = (n < 11) ? 1'($urandom_range(0, 1)) : 1'b0;
      send(0, 3'($urandom_range(0, 7)), 16'($urandom), 1'($urandom_range(0, 1)), kp, c1);
      if (!kp) wait_idle(0);
    end
    for (int n = 0; n < 12; n++) begin
      core[1] = 8'($urandom_range(0, 63));
      kp = (n < 11) ? 1'($urandom_range(0, 1)) : 1'b0;
      send(1, 3'($urandom_range(0, 7)), 16'($urandom), 1'($urandom_range(0, 1)), kp, c1);
      if (!kp) wait_idle(1);
    end

    repeat (5) @(posedge clk);
    #1;
    check("sb_drain", 128'(sb.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
